reg_bank16: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank16_if.sv | 31 +++
 rtl/reg_bank16_onehot_chk.sv | 24 ++
 rtl/reg_bank16.sv | 85 ++++++++
 tb/tb_reg_bank16.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 16-entry register bank, its write-select
// decoder and the control FSM.
package reg_bank_pkg;

    localparam int DW   = 16;   // data width of each register
    localparam int NREG = 16;   // one register per decoder output
    localparam int AW   = 4;    // log2(NREG)

    typedef logic [DW-1:0]   data_t;
    typedef logic [NREG-1:0] strobe_t;   // one-hot write strobes from dec16
    typedef logic [AW-1:0]   addr_t;

    localparam data_t REG_RST_VAL = '0;

endpackage

// File: rtl/reg_bank16_if.sv
// Bus bundle between the datapath control (master) and the register bank (slave).
//
// Handshake: there is no back-pressure. The master presents we/wdata and
// rd_en/raddr_* as level signals sampled on every rising clk edge; the bank
// answers a sampled rd_en=1 with rvalid=1 one cycle later, and rdata_a/rdata_b
// are only meaningful as fresh data while rvalid=1 (they hold otherwise).
interface reg_bank16_if;
    import reg_bank_pkg::*;

    strobe_t we;
    data_t   wdata;
    logic    rd_en;
    addr_t   raddr_a;
    addr_t   raddr_b;
    logic    clr_err;
    data_t   rdata_a;
    data_t   rdata_b;
    logic    rvalid;
    logic    err_multi;

    modport master (
        output we, wdata, rd_en, raddr_a, raddr_b, clr_err,
        input  rdata_a, rdata_b, rvalid, err_multi
    );

    modport slave (
        input  we, wdata, rd_en, raddr_a, raddr_b, clr_err,
        output rdata_a, rdata_b, rvalid, err_multi
    );

endinterface

// File: rtl/reg_bank16_onehot_chk.sv
// Combinational classifier for a strobe vector: zero-hot, one-hot or multi-hot.
// Exactly one of the three outputs is high for any input.
module onehot_chk #(
    parameter int N = 16
) (
    input  logic [N-1:0] vec_i,
    output logic         is_zero,
    output logic         is_onehot,
    output logic         is_multi
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic clear_lsb_zero;

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    always_comb begin
        clear_lsb_zero = ((vec_i & (vec_i - ONE)) == '0);
        is_zero        = (vec_i == '0);
        is_onehot      = !is_zero && clear_lsb_zero;
        is_multi       = !is_zero && !clear_lsb_zero;
    end

endmodule

// File: rtl/reg_bank16.sv
// Sixteen-entry register bank with two registered read ports, fed by the
// one-hot strobes of dec16. Multi-hot strobes are dropped and flagged in a
// sticky err_multi.
// Optional feature: REG_BANK16_BYPASS_EN forwards a same-cycle legal write
// into a read port addressing the written register.
module reg_bank16
    import reg_bank_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    reg_bank16_if.slave   bus
);

    data_t regs_q [NREG];
    data_t regs_d [NREG];
    data_t rdata_a_q, rdata_a_d;
    data_t rdata_b_q, rdata_b_d;
    logic  rvalid_q,  rvalid_d;
    logic  err_q,     err_d;

    logic we_zero, we_onehot, we_multi;

    onehot_chk #(.N(NREG)) u_onehot_chk (
        .vec_i     (bus.we),
        .is_zero   (we_zero),
        .is_onehot (we_onehot),
        .is_multi  (we_multi)
    );

    // Next-state: apply a legal write, select read data, update sticky error.
    always_comb begin
        regs_d = regs_q;
        if (we_onehot) begin
            for (int i = 0; i < NREG; i++) begin
                if (bus.we[i]) regs_d[i] = bus.wdata;
            end
        end

        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (bus.rd_en) begin
`ifdef REG_BANK16_BYPASS_EN
            // regs_d already carries a legal same-cycle write, so reading it forwards wdata.
            rdata_a_d = regs_d[bus.raddr_a];
            rdata_b_d = regs_d[bus.raddr_b];
`else
            rdata_a_d = regs_q[bus.raddr_a];
            rdata_b_d = regs_q[bus.raddr_b];
`endif
        end
        rvalid_d = bus.rd_en;

        // Set has priority over clear so a coincident bad pattern is never lost.
        if (we_multi)         err_d = 1'b1;
        else if (bus.clr_err) err_d = 1'b0;
        else                  err_d = err_q;
    end

    // State registers; reset discards any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= REG_RST_VAL;
            rdata_a_q <= REG_RST_VAL;
            rdata_b_q <= REG_RST_VAL;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign bus.rdata_a   = rdata_a_q;
    assign bus.rdata_b   = rdata_b_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.err_multi = err_q;

    // we_zero is part of the classifier contract; a zero-hot cycle simply writes nothing.
    logic unused_zero;
    assign unused_zero = we_zero;

endmodule

// File: tb/tb_reg_bank16.sv
// Self-checking bench for reg_bank16: directed scenarios plus randomized
// traffic compared against a register-array reference model.
module tb_reg_bank16;
    import reg_bank_pkg::*;

    logic clk;
    logic rst_n;

    reg_bank16_if bus ();

    reg_bank16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_reg [16];
    logic [15:0] m_a, m_b;
    logic        m_v, m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_a = 16'h0; m_b = 16'h0; m_v = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rdata_a"},   bus.rdata_a,          m_a);
        check({tag, ".rdata_b"},   bus.rdata_b,          m_b);
        check({tag, ".rvalid"},    {15'h0, bus.rvalid},    {15'h0, m_v});
        check({tag, ".err_multi"}, {15'h0, bus.err_multi}, {15'h0, m_err});
    endtask

    task automatic drive_idle();
        bus.we = '0; bus.wdata = '0; bus.rd_en = 1'b0;
        bus.raddr_a = '0; bus.raddr_b = '0; bus.clr_err = 1'b0;
    endtask

    // One clock cycle of stimulus; the model applies the rules in plain terms.
    task automatic step(input string tag, input logic [15:0] we, input logic [15:0] wd,
                        input logic rd, input logic [3:0] ra, input logic [3:0] rb,
                        input logic clr);
        int nbits;
        int widx;
        @(negedge clk);
        bus.we = we; bus.wdata = wd; bus.rd_en = rd;
        bus.raddr_a = ra; bus.raddr_b = rb; bus.clr_err = clr;

        nbits = $countones(we);
        widx  = -1;
        for (int i = 0; i < 16; i++) if (we[i]) widx = i;

        if (rd) begin
            m_a = m_reg[ra];
            m_b = m_reg[rb];
`ifdef REG_BANK16_BYPASS_EN
            if (nbits == 1 && widx == int'(ra)) m_a = wd;
            if (nbits == 1 && widx == int'(rb)) m_b = wd;
`endif
        end
        m_v = rd;
        if (nbits == 1) m_reg[widx] = wd;
        if (nbits > 1)  m_err = 1'b1;
        else if (clr)   m_err = 1'b0;

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    logic [15:0] rnd_we;
    int          kind;

    initial begin
        model_reset();
        drive_idle();

        // Reset held with inputs toggling: outputs must stay at zero.
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.we = 16'h1 << c; bus.wdata = 16'hFFFF; bus.rd_en = c[0];
            bus.raddr_a = 4'(c);
            check_outputs("in_reset");
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // All registers read zero after release.
        for (int i = 0; i < 16; i += 2) step("post_reset_rd", 16'h0, 16'h0, 1'b1, 4'(i), 4'(i + 1), 1'b0);

        // Basic write then dual read.
        step("wr3",    16'h0008, 16'hA5A5, 1'b0, 4'd0, 4'd0, 1'b0);
        step("wr15",   16'h8000, 16'h1234, 1'b0, 4'd0, 4'd0, 1'b0);
        step("rd3_15", 16'h0000, 16'h0000, 1'b1, 4'd3, 4'd15, 1'b0);
        check("rd3_dir",  bus.rdata_a, 16'hA5A5);
        check("rd15_dir", bus.rdata_b, 16'h1234);

        // Hold for three idle cycles after a read.
        for (int i = 0; i < 3; i++) step("hold", 16'h0, 16'h0, 1'b0, 4'd9, 4'd9, 1'b0);
        check("hold_dir", bus.rdata_a, 16'hA5A5);

        // Multi-hot write is dropped and flagged; clear; coincident set wins.
        step("pre_w0",   16'h0001, 16'h1111, 1'b0, 4'd0, 4'd0, 1'b0);
        step("pre_w4",   16'h0010, 16'h4444, 1'b0, 4'd0, 4'd0, 1'b0);
        step("multi",    16'h0011, 16'hFFFF, 1'b0, 4'd0, 4'd0, 1'b0);
        check("multi_err_dir", {15'h0, bus.err_multi}, 16'h0001);
        step("multi_rd", 16'h0000, 16'h0000, 1'b1, 4'd0, 4'd4, 1'b0);
        check("multi_keep0", bus.rdata_a, 16'h1111);
        check("multi_keep4", bus.rdata_b, 16'h4444);
        step("clr",      16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b1);
        step("multi2",   16'h0300, 16'hFFFF, 1'b0, 4'd0, 4'd0, 1'b0);
        step("clr_set",  16'h0300, 16'hFFFF, 1'b0, 4'd0, 4'd0, 1'b1);
        step("clr2",     16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b1);

        // Same-cycle write and read of one register.
        step("w2_init",  16'h0004, 16'h0001, 1'b0, 4'd0, 4'd0, 1'b0);
        step("w2_rd2",   16'h0004, 16'hBEEF, 1'b1, 4'd2, 4'd2, 1'b0);
        step("rd2_next", 16'h0000, 16'h0000, 1'b1, 4'd2, 4'd5, 1'b0);
        // Multi-hot including the read target never forwards.
        step("multi_rd2", 16'h0006, 16'h7777, 1'b1, 4'd2, 4'd1, 1'b0);

        // Asynchronous reset in the middle of a write cycle.
        step("w7",     16'h0080, 16'h5555, 1'b1, 4'd7, 4'd3, 1'b0);
        step("setErr", 16'h0003, 16'h0000, 1'b1, 4'd7, 4'd7, 1'b0);
        @(negedge clk);
        bus.we = 16'h0080; bus.wdata = 16'h1111; bus.rd_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step("first_wr", 16'h0002, 16'h0ABC, 1'b1, 4'd7, 4'd1, 1'b0);
        step("rd7_1",    16'h0000, 16'h0000, 1'b1, 4'd7, 4'd1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       rnd_we = 16'h0000;
                1, 2:    rnd_we = 16'h1 << $urandom_range(0, 15);
                default: begin
                    rnd_we = 16'h1 << $urandom_range(0, 7);
                    rnd_we = rnd_we | (16'h100 << $urandom_range(0, 7)) | 16'($urandom);
                end
            endcase
            step("rand", rnd_we, 16'($urandom), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
